// File: rtl/tinyqv_time_prescaler.sv
// Fractional clock divider producing the 1 us time_pulse strobe for mtime; pulse is registered
// and lands N (or N+1 with carry) cycles after each reload; no backpressure, divisor writes defer to the next tick.
module tinyqv_time_prescaler #(
    parameter int INT_BITS   = 8,
    parameter int FRAC_BITS  = 4,
    parameter int RESET_INT  = 64,
    parameter int RESET_FRAC = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic                          debug_halt,
    input  logic                          set_div,
    input  logic [INT_BITS+FRAC_BITS-1:0] div_in,
    output logic [INT_BITS+FRAC_BITS-1:0] div_out,
    output logic                          div_pending,
    output logic                          time_pulse
);

    localparam logic [INT_BITS-1:0]  ONE       = INT_BITS'(1);
    localparam logic [INT_BITS-1:0]  TWO       = INT_BITS'(2);
    localparam logic [INT_BITS-1:0]  RST_INT   = INT_BITS'(RESET_INT);
    localparam logic [FRAC_BITS-1:0] RST_FRAC  = FRAC_BITS'(RESET_FRAC);
    localparam logic [INT_BITS-1:0]  RST_CNT   = (RESET_INT < 2) ? ONE : INT_BITS'(RESET_INT - 1);

    logic [INT_BITS-1:0]  div_int;
    logic [FRAC_BITS-1:0] div_frac;
    logic [INT_BITS-1:0]  pend_int;
    logic [FRAC_BITS-1:0] pend_frac;
    logic                 pend_valid;
    logic [INT_BITS-1:0]  cnt;
    logic [FRAC_BITS-1:0] acc;

    logic [INT_BITS-1:0]  eff_int;
    logic [FRAC_BITS-1:0] eff_frac;
    logic [INT_BITS-1:0]  eff_n;
    logic [FRAC_BITS-1:0] frac_add;
    logic [FRAC_BITS:0]   acc_sum;
    logic [INT_BITS-1:0]  reload_cnt;
    logic [INT_BITS-1:0]  dis_int;
    logic [FRAC_BITS-1:0] dis_frac;
    logic [INT_BITS-1:0]  dis_cnt;

    // Divisors below 2 clamp to period 2 with no fractional carry, so pulses never touch.
    always_comb begin
        eff_int    = pend_valid ? pend_int  : div_int;
        eff_frac   = pend_valid ? pend_frac : div_frac;
        eff_n      = (eff_int < TWO) ? TWO : eff_int;
        frac_add   = (eff_int < TWO) ? '0 : eff_frac;
        acc_sum    = {1'b0, acc} + {1'b0, frac_add};
        reload_cnt = eff_n - ONE + {{(INT_BITS-1){1'b0}}, acc_sum[FRAC_BITS]};

        dis_int    = set_div ? div_in[INT_BITS+FRAC_BITS-1:FRAC_BITS] : eff_int;
        dis_frac   = set_div ? div_in[FRAC_BITS-1:0]                  : eff_frac;
        dis_cnt    = (dis_int < TWO) ? ONE : dis_int - ONE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_int    <= RST_INT;
            div_frac   <= RST_FRAC;
            pend_int   <= '0;
            pend_frac  <= '0;
            pend_valid <= 1'b0;
            cnt        <= RST_CNT;
            acc        <= '0;
            time_pulse <= 1'b0;
        end else if (!enable) begin
            div_int    <= dis_int;
            div_frac   <= dis_frac;
            pend_valid <= 1'b0;
            cnt        <= dis_cnt;
            acc        <= '0;
            time_pulse <= 1'b0;
        end else begin
            if (set_div) begin
                pend_int   <= div_in[INT_BITS+FRAC_BITS-1:FRAC_BITS];
                pend_frac  <= div_in[FRAC_BITS-1:0];
                pend_valid <= 1'b1;
            end
            if (debug_halt) begin
                time_pulse <= 1'b0;
            end else if (cnt != '0) begin
                cnt        <= cnt - ONE;
                time_pulse <= 1'b0;
            end else begin
                // A write landing on this reload edge stays pending for the next one.
                div_int    <= eff_int;
                div_frac   <= eff_frac;
                acc        <= acc_sum[FRAC_BITS-1:0];
                cnt        <= reload_cnt;
                time_pulse <= 1'b1;
                if (!set_div) pend_valid <= 1'b0;
            end
        end
    end

    assign div_out     = pend_valid ? {pend_int, pend_frac} : {div_int, div_frac};
    assign div_pending = pend_valid;

endmodule

// File: tb/tb_tinyqv_time_prescaler.sv
// Directed bench for tinyqv_time_prescaler: pulse timing, fractional spacing, pending writes, halt and reset.
module tb_tinyqv_time_prescaler;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        debug_halt;
    logic        set_div;
    logic [11:0] div_in;
    logic [11:0] div_out;
    logic        div_pending;
    logic        time_pulse;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int adj      = 0;
    logic prev_pulse = 1'b0;

    tinyqv_time_prescaler #(
        .INT_BITS(8), .FRAC_BITS(4), .RESET_INT(64), .RESET_FRAC(0)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .debug_halt(debug_halt),
        .set_div(set_div), .div_in(div_in), .div_out(div_out),
        .div_pending(div_pending), .time_pulse(time_pulse)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    // One clock; samples 1 time unit after the edge and tracks back-to-back pulses.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (time_pulse && prev_pulse) adj++;
        prev_pulse = time_pulse;
    endtask

    task automatic wait_pulse(input string tag, output int t);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!time_pulse && n < 400);
        if (!time_pulse) check({tag, "_timeout"}, 32'd0, 32'd1);
        t = cyc;
    endtask

    task automatic do_reset();
        rst = 1'b1; enable = 1'b1; debug_halt = 1'b0; set_div = 1'b0; div_in = '0;
        tick();
        tick();
        rst = 1'b0;
        cyc = 0;
    endtask

    initial begin
        int t;
        int prev;
        int exp_iv[5];
        exp_iv = '{66, 66, 67, 66, 67};

        // Reset state and divisor 64.0
        rst = 1'b1; enable = 1'b1; debug_halt = 1'b0; set_div = 1'b0; div_in = '0;
        tick();
        tick();
        check("rst_pulse",   32'(time_pulse),  32'd0);
        check("rst_pending", 32'(div_pending), 32'd0);
        check("rst_div_out", 32'(div_out),     32'h400);
        rst = 1'b0;
        cyc = 0;
        wait_pulse("p64", t);  check("pulse1_at", t, 64);
        tick();                check("pulse1_width", 32'(time_pulse), 32'd0);
        wait_pulse("p128", t); check("pulse2_at", t, 128);
        wait_pulse("p192", t); check("pulse3_at", t, 192);
        check("div_out_64", 32'(div_out), 32'h400);

        // Fractional divisor 66.5 written while disabled
        enable = 1'b0;
        tick();
        set_div = 1'b1; div_in = 12'h428;
        tick();
        set_div = 1'b0;
        check("dis_div_out", 32'(div_out),     32'h428);
        check("dis_pending", 32'(div_pending), 32'd0);
        enable = 1'b1;
        cyc = 0;
        prev = 0;
        for (int i = 0; i < 200; i++) begin
            wait_pulse("frac", t);
            if (i < 5) check($sformatf("frac_interval%0d", i), t - prev, exp_iv[i]);
            prev = t;
        end
        check("frac_total200", t, 13299);

        // Minimum divisors clamp to a period of 2
        enable = 1'b0; set_div = 1'b1; div_in = 12'h01F;
        tick();
        set_div = 1'b0; enable = 1'b1;
        cyc = 0;
        wait_pulse("min1", t); check("min1_p1", t, 2);
        wait_pulse("min1", t); check("min1_p2", t, 4);
        wait_pulse("min1", t); check("min1_p3", t, 6);
        enable = 1'b0; set_div = 1'b1; div_in = 12'h000;
        tick();
        set_div = 1'b0; enable = 1'b1;
        check("zero_div_out", 32'(div_out), 32'h000);
        cyc = 0;
        wait_pulse("min0", t); check("min0_p1", t, 2);
        wait_pulse("min0", t); check("min0_p2", t, 4);

        // Pending write while running at 64.0
        do_reset();
        while (cyc < 20) tick();
        set_div = 1'b1; div_in = 12'h0A0;
        tick();
        set_div = 1'b0;
        check("pend_rise",    32'(div_pending), 32'd1);
        check("pend_div_out", 32'(div_out),     32'h0A0);
        while (cyc < 63) tick();
        check("pend_hold63",  32'(div_pending), 32'd1);
        check("pend_nopulse", 32'(time_pulse),  32'd0);
        tick();
        check("pend_fall64",  32'(div_pending), 32'd0);
        check("pend_pulse64", 32'(time_pulse),  32'd1);
        check("pend_applied", 32'(div_out),     32'h0A0);
        wait_pulse("p74", t); check("new_div_p74", t, 74);
        wait_pulse("p84", t); check("new_div_p84", t, 84);

        // Debug halt over cycles 30..39
        do_reset();
        while (cyc < 30) tick();
        debug_halt = 1'b1;
        while (cyc < 40) tick();
        debug_halt = 1'b0;
        wait_pulse("halt1", t); check("halt_p74",  t, 74);
        wait_pulse("halt2", t); check("halt_p138", t, 138);

        // Reset mid-period discards a pending write
        do_reset();
        while (cyc < 20) tick();
        set_div = 1'b1; div_in = 12'h0A0;
        tick();
        set_div = 1'b0;
        while (cyc < 40) tick();
        rst = 1'b1;
        tick();
        check("midrst_pulse",   32'(time_pulse),  32'd0);
        check("midrst_pending", 32'(div_pending), 32'd0);
        check("midrst_div_out", 32'(div_out),     32'h400);
        rst = 1'b0;
        cyc = 0;
        wait_pulse("postrst", t); check("postrst_p64", t, 64);

        check("no_adjacent_pulses", adj, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
